// File: rtl/dsp_w_router.sv
// -----------------------------------------------------------------------------
// dsp_w_router
//
// Write-data router for an AXI-style crossbar. The AW dispatcher pushes one
// route ({decerr, slv_id}) per accepted write address into a routing FIFO.
// The route at the FIFO head steers the master W channel to one slave port
// until the WLAST beat completes, then the head pops. Decode-error routes
// sink the burst locally: the master sees ready, no slave sees valid, and
// dsp_B_decerr_o pulses once on the cycle after the sunk WLAST beat.
//
// Configuration macro:
//   DSP_W_ROUTER_SKID_EN  defined   -> two-entry skid buffer between routing
//                                      and the slave ports (1-cycle latency,
//                                      full throughput).
//                         undefined -> master-to-slave path is combinational.
//
// Ports:
//   ACLK_i           clock, rising edge
//   ARESET_i         synchronous active-high reset
//   m_WDATA_i        master write data
//   m_WSTRB_i        master write strobe
//   m_WLAST_i        master last beat of burst
//   m_WVALID_i       master beat valid
//   m_WREADY_o       master beat accepted
//   dsp_AW_push_i    dispatcher pushes one route
//   dsp_AW_slv_id_i  target slave of the pushed route
//   dsp_AW_decerr_i  pushed route is a decode error
//   dsp_AW_full_o    routing FIFO full
//   sa_WDATA_o       write data, broadcast to every slave
//   sa_WSTRB_o       write strobe, broadcast to every slave
//   sa_WLAST_o       WLAST, broadcast to every slave
//   sa_WVALID_o      one-hot beat valid per slave
//   sa_WREADY_i      per-slave ready
//   dsp_B_decerr_o   one-cycle pulse when a decode-error burst completes
// -----------------------------------------------------------------------------
module dsp_w_router #(
   parameter int SLV_AMT     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int OUTST_DEPTH = 4,
   parameter int SLV_ID_W    = $clog2(SLV_AMT)
) (
   input  logic                             ACLK_i,
   input  logic                             ARESET_i,
   input  logic [DATA_WIDTH-1:0]            m_WDATA_i,
   input  logic [DATA_WIDTH/8-1:0]          m_WSTRB_i,
   input  logic                             m_WLAST_i,
   input  logic                             m_WVALID_i,
   output logic                             m_WREADY_o,
   input  logic                             dsp_AW_push_i,
   input  logic [SLV_ID_W-1:0]              dsp_AW_slv_id_i,
   input  logic                             dsp_AW_decerr_i,
   output logic                             dsp_AW_full_o,
   output logic [DATA_WIDTH*SLV_AMT-1:0]    sa_WDATA_o,
   output logic [DATA_WIDTH/8*SLV_AMT-1:0]  sa_WSTRB_o,
   output logic [SLV_AMT-1:0]               sa_WLAST_o,
   output logic [SLV_AMT-1:0]               sa_WVALID_o,
   input  logic [SLV_AMT-1:0]               sa_WREADY_i,
   output logic                             dsp_B_decerr_o
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = $clog2(OUTST_DEPTH + 1);
   localparam int PTR_W  = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;

   typedef struct packed {
      logic                decerr;
      logic [SLV_ID_W-1:0] slv_id;
   } route_t;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUTST_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // ---------------------------------------------------------------------------
   // Routing FIFO
   // ---------------------------------------------------------------------------
   route_t             route_mem [OUTST_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   occupancy;
   logic               full;
   logic               head_valid;
   route_t             head;
   route_t             new_route;
   logic               push;
   logic               pop;
   logic               in_ready;
   logic               stage_ready;
   logic               fwd_valid;
   logic               beat_fire;
   logic               decerr_pulse;

   assign full       = (occupancy == CNT_W'(OUTST_DEPTH));
   assign head_valid = (occupancy != '0);
   assign head       = route_mem[rd_ptr];
   assign push       = dsp_AW_push_i && !full;

   // An out-of-range slave ID can never be routed, so it is folded into decerr.
   assign new_route.decerr = dsp_AW_decerr_i || (int'(dsp_AW_slv_id_i) >= SLV_AMT);
   assign new_route.slv_id = dsp_AW_slv_id_i;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         occupancy    <= '0;
         decerr_pulse <= 1'b0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)      occupancy <= occupancy + 1'b1;
         else if (pop && !push) occupancy <= occupancy - 1'b1;
         decerr_pulse <= pop && head.decerr;
      end
   end

   // NOTE: storage arrays are not reset; occupancy alone decides which entries
   // are live, and leaving the data unreset keeps it in plain RAM/flops.
   always_ff @(posedge ACLK_i) begin
      if (push) route_mem[wr_ptr] <= new_route;
   end

   // Head route control. The head only changes on pop, i.e. after the WLAST
   // handshake, so the route is stable for the whole burst.
   // NOTE: defaults are assigned first so every path drives every signal and
   // no latch is inferred.
   always_comb begin
      in_ready = 1'b0;
      if (head_valid && !ARESET_i) begin
         in_ready = head.decerr ? 1'b1 : stage_ready;
      end
   end

   assign fwd_valid = head_valid && !head.decerr && m_WVALID_i && !ARESET_i;
   assign beat_fire = m_WVALID_i && in_ready;
   assign pop       = beat_fire && m_WLAST_i;

   // ---------------------------------------------------------------------------
   // Slave-side stage
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] out_data;
   logic [STRB_W-1:0]     out_strb;
   logic                  out_last;
   logic [SLV_AMT-1:0]    out_valid_oh;

`ifdef DSP_W_ROUTER_SKID_EN
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [STRB_W-1:0]     strb;
      logic                  last;
      logic [SLV_ID_W-1:0]   slv_id;
   } beat_t;

   beat_t      skid_mem [2];
   logic       skid_wr;
   logic       skid_rd;
   logic [1:0] skid_cnt;
   beat_t      skid_out;
   logic       skid_out_valid;
   logic       skid_push;
   logic       skid_pop;

   // Ready depends only on registered occupancy, so the master path never
   // sees slave ready combinationally; two entries keep full throughput.
   assign stage_ready    = (skid_cnt != 2'd2);
   assign skid_push      = fwd_valid && stage_ready;
   assign skid_out       = skid_mem[skid_rd];
   assign skid_out_valid = (skid_cnt != 2'd0) && !ARESET_i;
   assign skid_pop       = skid_out_valid && sa_WREADY_i[skid_out.slv_id];

   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         skid_wr  <= 1'b0;
         skid_rd  <= 1'b0;
         skid_cnt <= 2'd0;
      end else begin
         if (skid_push) skid_wr <= ~skid_wr;
         if (skid_pop)  skid_rd <= ~skid_rd;
         case ({skid_push, skid_pop})
            2'b10:   skid_cnt <= skid_cnt + 2'd1;
            2'b01:   skid_cnt <= skid_cnt - 2'd1;
            default: skid_cnt <= skid_cnt;
         endcase
      end
   end

   always_ff @(posedge ACLK_i) begin
      if (skid_push) skid_mem[skid_wr] <= '{data:   m_WDATA_i,
                                            strb:   m_WSTRB_i,
                                            last:   m_WLAST_i,
                                            slv_id: head.slv_id};
   end

   always_comb begin
      out_valid_oh = '0;
      if (skid_out_valid) out_valid_oh[skid_out.slv_id] = 1'b1;
   end

   assign out_data = skid_out.data;
   assign out_strb = skid_out.strb;
   assign out_last = skid_out.last;
`else
   assign stage_ready = sa_WREADY_i[head.slv_id];

   always_comb begin
      out_valid_oh = '0;
      if (fwd_valid) out_valid_oh[head.slv_id] = 1'b1;
   end

   assign out_data = m_WDATA_i;
   assign out_strb = m_WSTRB_i;
   assign out_last = m_WLAST_i;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign m_WREADY_o     = in_ready;
   assign dsp_AW_full_o  = full && !ARESET_i;
   assign sa_WVALID_o    = out_valid_oh;
   assign sa_WDATA_o     = {SLV_AMT{out_data}};
   assign sa_WSTRB_o     = {SLV_AMT{out_strb}};
   assign sa_WLAST_o     = {SLV_AMT{out_last}};
   assign dsp_B_decerr_o = decerr_pulse;

endmodule

// File: tb/tb_dsp_w_router.sv
// -----------------------------------------------------------------------------
// tb_dsp_w_router
//
// Directed bench for dsp_w_router with a scoreboard: each routed beat is
// queued with its expected slave, data, strobe and last flag when issued; a
// monitor pops and compares whenever a slave handshake is presented. Works
// with and without DSP_W_ROUTER_SKID_EN (latency-independent checking).
// -----------------------------------------------------------------------------
module tb_dsp_w_router;

   localparam int SLV_AMT = 4;
   localparam int DW      = 32;
   localparam int DEPTH   = 4;
   localparam int IDW     = 2;

   logic                    ACLK_i = 1'b0;
   logic                    ARESET_i;
   logic [DW-1:0]           m_WDATA_i;
   logic [DW/8-1:0]         m_WSTRB_i;
   logic                    m_WLAST_i;
   logic                    m_WVALID_i;
   logic                    m_WREADY_o;
   logic                    dsp_AW_push_i;
   logic [IDW-1:0]          dsp_AW_slv_id_i;
   logic                    dsp_AW_decerr_i;
   logic                    dsp_AW_full_o;
   logic [DW*SLV_AMT-1:0]   sa_WDATA_o;
   logic [DW/8*SLV_AMT-1:0] sa_WSTRB_o;
   logic [SLV_AMT-1:0]      sa_WLAST_o;
   logic [SLV_AMT-1:0]      sa_WVALID_o;
   logic [SLV_AMT-1:0]      sa_WREADY_i;
   logic                    dsp_B_decerr_o;

   dsp_w_router #(
      .SLV_AMT(SLV_AMT), .DATA_WIDTH(DW), .OUTST_DEPTH(DEPTH), .SLV_ID_W(IDW)
   ) dut (
      .ACLK_i(ACLK_i), .ARESET_i(ARESET_i),
      .m_WDATA_i(m_WDATA_i), .m_WSTRB_i(m_WSTRB_i), .m_WLAST_i(m_WLAST_i),
      .m_WVALID_i(m_WVALID_i), .m_WREADY_o(m_WREADY_o),
      .dsp_AW_push_i(dsp_AW_push_i), .dsp_AW_slv_id_i(dsp_AW_slv_id_i),
      .dsp_AW_decerr_i(dsp_AW_decerr_i), .dsp_AW_full_o(dsp_AW_full_o),
      .sa_WDATA_o(sa_WDATA_o), .sa_WSTRB_o(sa_WSTRB_o), .sa_WLAST_o(sa_WLAST_o),
      .sa_WVALID_o(sa_WVALID_o), .sa_WREADY_i(sa_WREADY_i),
      .dsp_B_decerr_o(dsp_B_decerr_o)
   );

   always #5 ACLK_i = ~ACLK_i;

   typedef struct {
      int            slv;
      logic [DW-1:0] data;
      logic [3:0]    strb;
      logic          last;
   } beat_t;

   beat_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc = 0;
   int    decerr_pulses = 0;
   bit    sb_en = 1'b0;
   bit    chk_decerr = 1'b0;
   bit    toggle_en = 1'b0;
   bit    chk_mirror = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge ACLK_i) cyc++;

   // Scoreboard monitor: samples on the falling edge, away from the active edge.
   always @(negedge ACLK_i) begin
      beat_t e;
      int    k;
      if (ARESET_i === 1'b0) begin
         if (dsp_B_decerr_o === 1'b1) decerr_pulses++;
         if (sb_en && ((sa_WVALID_o & sa_WREADY_i) != '0)) begin
            k = 0;
            for (int i = SLV_AMT - 1; i >= 0; i--) if (sa_WVALID_o[i]) k = i;
            check("valid_onehot", 64'($countones(sa_WVALID_o)), 64'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'(sa_WVALID_o), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("beat_slave", 64'(sa_WVALID_o), 64'(1 << e.slv));
               check("beat_data",  64'(sa_WDATA_o[k*DW +: DW]), 64'(e.data));
               check("beat_strb",  64'(sa_WSTRB_o[k*4 +: 4]), 64'(e.strb));
               check("beat_last",  64'(sa_WLAST_o[k]), 64'(e.last));
            end
         end
      end
   end

   task automatic push_route(input logic [IDW-1:0] id, input logic decerr);
      dsp_AW_push_i   = 1'b1;
      dsp_AW_slv_id_i = id;
      dsp_AW_decerr_i = decerr;
      @(posedge ACLK_i); #1;
      dsp_AW_push_i   = 1'b0;
      dsp_AW_decerr_i = 1'b0;
   endtask

   // Present one beat and hold it until the handshake edge (bounded).
   task automatic send_beat(input logic [DW-1:0] d, input logic [3:0] s, input logic last);
      int budget = 0;
      m_WVALID_i = 1'b1;
      m_WDATA_i  = d;
      m_WSTRB_i  = s;
      m_WLAST_i  = last;
      forever begin
         @(negedge ACLK_i);
         if (chk_mirror) check("ready_mirror", 64'(m_WREADY_o), 64'(sa_WREADY_i[1]));
         if (chk_decerr) begin
            check("decerr_ready",    64'(m_WREADY_o), 64'd1);
            check("decerr_no_valid", 64'(sa_WVALID_o), 64'd0);
         end
         if (m_WREADY_o === 1'b1) break;
         budget++;
         if (budget > 50) begin
            check("beat_timeout", 64'(m_WREADY_o), 64'd1);
            break;
         end
         @(posedge ACLK_i); #1;
         if (toggle_en) sa_WREADY_i[1] = ~sa_WREADY_i[1];
      end
      @(posedge ACLK_i); #1;
      if (toggle_en) sa_WREADY_i[1] = ~sa_WREADY_i[1];
      m_WVALID_i = 1'b0;
      m_WLAST_i  = 1'b0;
   endtask

   // slv < 0 means the burst is sunk (decode error): nothing is expected.
   task automatic send_burst(input int slv, input int n, input logic [DW-1:0] base,
                             input logic [3:0] s);
      for (int b = 0; b < n; b++) begin
         if (slv >= 0) exp_q.push_back('{slv: slv, data: base + DW'(b), strb: s, last: (b == n - 1)});
         send_beat(base + DW'(b), s, (b == n - 1));
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge ACLK_i);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wready"},  64'(m_WREADY_o),     64'd0);
      check({tag, "_full"},    64'(dsp_AW_full_o),  64'd0);
      check({tag, "_svalid"},  64'(sa_WVALID_o),    64'd0);
      check({tag, "_decerr"},  64'(dsp_B_decerr_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      ARESET_i        = 1'b1;
      m_WDATA_i       = '0;
      m_WSTRB_i       = '0;
      m_WLAST_i       = 1'b0;
      m_WVALID_i      = 1'b0;
      dsp_AW_push_i   = 1'b0;
      dsp_AW_slv_id_i = '0;
      dsp_AW_decerr_i = 1'b0;
      sa_WREADY_i     = 4'hF;

      // Reset state
      repeat (2) @(posedge ACLK_i);
      @(negedge ACLK_i);
      check_reset_outputs("reset");
      @(posedge ACLK_i); #1;
      ARESET_i = 1'b0;
      sb_en    = 1'b1;

      // Single route to slave 2; no bypass in the push cycle.
      dsp_AW_push_i   = 1'b1;
      dsp_AW_slv_id_i = 2'd2;
      m_WVALID_i      = 1'b1;
      m_WDATA_i       = 32'hDEAD_0000;
      @(negedge ACLK_i);
      check("no_bypass_wready", 64'(m_WREADY_o),  64'd0);
      check("no_bypass_svalid", 64'(sa_WVALID_o), 64'd0);
      @(posedge ACLK_i); #1;
      dsp_AW_push_i = 1'b0;
      send_burst(2, 4, 32'hA000_0010, 4'hF);
      @(negedge ACLK_i);
      check("single_empty_wready", 64'(m_WREADY_o),    64'd0);
      check("single_empty_full",   64'(dsp_AW_full_o), 64'd0);
      wait_drain();

      // Fill: four routes fill the FIFO, the fifth is dropped.
      for (int i = 0; i < 4; i++) push_route(IDW'(i), 1'b0);
      @(negedge ACLK_i);
      check("fill_full", 64'(dsp_AW_full_o), 64'd1);
      @(posedge ACLK_i); #1;
      push_route(2'd1, 1'b0);
      @(negedge ACLK_i);
      check("fill_still_full", 64'(dsp_AW_full_o), 64'd1);
      @(posedge ACLK_i); #1;
      start = cyc;
      send_burst(0, 2, 32'hB000_0000, 4'h1);
      send_burst(1, 2, 32'hB100_0000, 4'h3);
      send_burst(2, 2, 32'hB200_0000, 4'h7);
      send_burst(3, 2, 32'hB300_0000, 4'hF);
      check("b2b_cycles", 64'(cyc - start), 64'd8);
      @(negedge ACLK_i);
      check("fill_5th_dropped", 64'(m_WREADY_o),    64'd0);
      check("fill_not_full",    64'(dsp_AW_full_o), 64'd0);
      wait_drain();

      // Decode error: burst sunk even with every slave stalled.
      sa_WREADY_i = 4'h0;
      push_route(2'd0, 1'b1);
      chk_decerr = 1'b1;
      send_burst(-1, 2, 32'hCCCC_0000, 4'hF);
      chk_decerr = 1'b0;
      @(negedge ACLK_i);
      check("decerr_pulse_high", 64'(dsp_B_decerr_o), 64'd1);
      @(negedge ACLK_i);
      check("decerr_pulse_low",  64'(dsp_B_decerr_o), 64'd0);
      check("decerr_empty",      64'(m_WREADY_o),     64'd0);
      sa_WREADY_i = 4'hF;
      @(posedge ACLK_i); #1;

      // Backpressure: slave 1 ready toggles every cycle.
      sa_WREADY_i = 4'b1101;
      push_route(2'd1, 1'b0);
      toggle_en = 1'b1;
`ifndef DSP_W_ROUTER_SKID_EN
      chk_mirror = 1'b1;
`endif
      send_burst(1, 6, 32'hD100_0000, 4'h5);
      chk_mirror  = 1'b0;
      toggle_en   = 1'b0;
      sa_WREADY_i = 4'hF;
      wait_drain();

      // Push at occupancy 1 on the same edge the WLAST beat pops.
      push_route(2'd0, 1'b0);
      exp_q.push_back('{slv: 0, data: 32'hE000_0000, strb: 4'hF, last: 1'b0});
      send_beat(32'hE000_0000, 4'hF, 1'b0);
      exp_q.push_back('{slv: 0, data: 32'hE000_0001, strb: 4'hF, last: 1'b1});
      dsp_AW_push_i   = 1'b1;
      dsp_AW_slv_id_i = 2'd3;
      send_beat(32'hE000_0001, 4'hF, 1'b1);
      dsp_AW_push_i = 1'b0;
      @(negedge ACLK_i);
      check("simul_new_head", 64'(m_WREADY_o),    64'd1);
      check("simul_not_full", 64'(dsp_AW_full_o), 64'd0);
      @(posedge ACLK_i); #1;
      send_burst(3, 2, 32'hE300_0000, 4'hF);
      @(negedge ACLK_i);
      check("simul_empty", 64'(m_WREADY_o), 64'd0);
      wait_drain();

      // Reset mid-burst after beat 2 of 4; the partial burst is not scored.
      sb_en = 1'b0;
      push_route(2'd2, 1'b0);
      send_beat(32'hF000_0000, 4'hF, 1'b0);
      send_beat(32'hF000_0001, 4'hF, 1'b0);
      m_WVALID_i = 1'b1;
      m_WDATA_i  = 32'hF000_0002;
      ARESET_i   = 1'b1;
      repeat (2) @(posedge ACLK_i);
      @(negedge ACLK_i);
      check_reset_outputs("midrst");
      @(posedge ACLK_i); #1;
      ARESET_i = 1'b0;
      @(negedge ACLK_i);
      check_reset_outputs("postrst");
      @(posedge ACLK_i); #1;
      m_WVALID_i = 1'b0;
      @(posedge ACLK_i); #1;
      sb_en = 1'b1;
      push_route(2'd2, 1'b0);
      send_burst(2, 4, 32'hA100_0020, 4'hA);
      @(negedge ACLK_i);
      check("fresh_empty_wready", 64'(m_WREADY_o), 64'd0);
      wait_drain();

      check("decerr_pulse_count", 64'(decerr_pulses), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dsp_w_router.md
DSP_W_ROUTER -- requirements
Module: dsp_w_router

Interface
REQ-001 SHALL have parameter SLV_AMT, default 4: number of slave ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: WDATA width in bits.
REQ-003 SHALL have parameter OUTST_DEPTH, default 4: routing-FIFO depth, i.e. the number of outstanding AW routes.
REQ-004 SHALL have parameter SLV_ID_W, default $clog2(SLV_AMT): slave ID width.
REQ-005 SHALL have these ports; ACLK_i and ARESET_i form one clock and a synchronous, active-high reset:
- ACLK_i  in  1  single clock, rising edge.
- ARESET_i  in  1  synchronous active-high reset.
- m_WDATA_i  in  DATA_WIDTH  master write data.
- m_WSTRB_i  in  DATA_WIDTH/8  master write strobe.
- m_WLAST_i  in  1  last beat of the burst.
- m_WVALID_i  in  1  master beat valid.
- m_WREADY_o  out  1  master beat accepted.
- dsp_AW_push_i  in  1  AW dispatcher pushes one route.
- dsp_AW_slv_id_i  in  SLV_ID_W  target slave of the pushed route.
- dsp_AW_decerr_i  in  1  pushed route is a decode error.
- dsp_AW_full_o  out  1  routing FIFO full.
- sa_WDATA_o  out  DATA_WIDTH*SLV_AMT  data, broadcast to every slave.
- sa_WSTRB_o  out  DATA_WIDTH/8*SLV_AMT  strobe, broadcast to every slave.
- sa_WLAST_o  out  SLV_AMT  WLAST, broadcast to every slave.
- sa_WVALID_o  out  SLV_AMT  one-hot beat valid per slave.
- sa_WREADY_i  in  SLV_AMT  per-slave ready.
- dsp_B_decerr_o  out  1  one-cycle pulse when a decode-error burst completes.

Function
REQ-006 SHALL hold an OUTST_DEPTH-entry FIFO of {decerr, slv_id} with an occupancy counter of width $clog2(OUTST_DEPTH+1).
- Read and write pointers wrap modulo OUTST_DEPTH.
REQ-007 SHALL assert dsp_AW_full_o exactly when occupancy == OUTST_DEPTH.
- Push happens when dsp_AW_push_i=1 and dsp_AW_full_o=0.
- A push while full is ignored and leaves the FIFO unchanged.
REQ-008 SHALL treat any pushed slv_id >= SLV_AMT as decerr=1.
REQ-009 SHALL not bypass the FIFO: a route pushed into an empty FIFO becomes the head one cycle later.
REQ-010 SHALL, when the FIFO is empty, drive m_WREADY_o=0 and all sa_WVALID_o=0.
REQ-011 SHALL, for a non-decerr head with ID k:
- drive sa_WVALID_o[k]=m_WVALID_i and all other sa_WVALID_o bits 0;
- drive m_WREADY_o=sa_WREADY_i[k].
REQ-012 SHALL, for a decerr head, sink the burst:
- drive m_WREADY_o=1 and all sa_WVALID_o=0;
- discard the data.
REQ-013 SHALL pop the head on the cycle a beat with m_WLAST_i=1 completes its handshake.
REQ-014 SHALL pulse dsp_B_decerr_o for one cycle, on the cycle after a decerr burst's last beat completes its handshake.
REQ-015 SHALL apply push and pop in the same cycle together, leaving occupancy unchanged; when full, the push is still refused (full is the registered flag).
REQ-016 SHALL route back-to-back bursts to different slaves with no idle cycle between the WLAST beat and the next burst's first beat.
REQ-017 SHALL never change the head route while a burst is mid-transfer.

Reset
REQ-018 SHALL, while ARESET_i=1 at a clock edge, clear the pointers and occupancy, clear the skid stage, and drive dsp_B_decerr_o=0.
REQ-019 SHALL produce these output values in reset: m_WREADY_o=0, dsp_AW_full_o=0, sa_WVALID_o=0.
- Data outputs are don't-care in reset.
REQ-020 SHALL discard in-flight bursts and routes on a reset asserted mid-burst, with no decerr pulse and no slave valid after release.

Configuration
REQ-021 SHALL support the macro DSP_W_ROUTER_SKID_EN.
REQ-022 SHALL, when DSP_W_ROUTER_SKID_EN is defined, insert a two-entry skid buffer between routing and the slave ports.
- Routing output to the slave ports: 1-cycle latency, full throughput.
- m_WREADY_o is the skid buffer's input ready.
- The pop and decerr timing of REQ-013/014 refer to the skid input handshake.
REQ-023 SHALL, when DSP_W_ROUTER_SKID_EN is undefined, make the path from master to slave purely combinational, with 0-cycle latency.

Verification
REQ-024 Bench SHALL cover:
- Single route: push id=2, then a 4-beat burst with sa_WREADY_i=4'hF -> sa_WVALID_o=4'b0100 on all 4 beats; FIFO empty after WLAST; m_WREADY_o=0 next cycle.
- Fill: 5 pushes with OUTST_DEPTH=4 and no W traffic -> dsp_AW_full_o=1 after the 4th push; the 5th push is dropped; bursts then drain to IDs 0,1,2,3 in push order.
- Decode error: push decerr=1, then a 2-beat burst with sa_WREADY_i=0 -> m_WREADY_o=1 on both beats; sa_WVALID_o=0; dsp_B_decerr_o pulses once, 1 cycle after WLAST.
- Backpressure: route id=1 with sa_WREADY_i[1] toggling 0/1 each cycle -> m_WREADY_o mirrors it; no beat lost or duplicated (data compared by scoreboard).
- Simultaneous events: push while the last beat pops at occupancy=1 -> occupancy stays 1 and the new route heads the next cycle. Also run with DSP_W_ROUTER_SKID_EN defined -> identical beat order with 1-cycle output latency.
- Reset mid-burst after beat 2 of 4 -> all outputs at reset values; a fresh route afterwards behaves as in the single-route case.
